segscan_rx: RTL
===============

SEGSCAN_RX -- requirements
Module: segscan_rx

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, meaning consecutive identical samples required before a digit is captured (legal range 2..15).
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all state on rising edge.
REQ-003 SHALL have port resetn, input, 1, meaning the reset, asynchronous and active-low.
REQ-004 SHALL have port seg_in, input, 7, meaning active-low segment lines (bit6=g … bit0=a), asynchronous to clock.
REQ-005 SHALL have port dig_en_n, input, 8, meaning active-low one-hot digit select of the scanned display, asynchronous to clock.
REQ-006 SHALL have port frame_data, output, 32, meaning the assembled word, digit i in bits [4i+3:4i].
REQ-007 SHALL have port frame_valid, output, 1, meaning frame_data holds an unconsumed frame.
REQ-008 SHALL have port frame_ready, input, 1, meaning the consumer accepts the frame.
REQ-009 SHALL have port dig_err, output, 1, meaning a one-cycle pulse on a stable unrecognised pattern.
REQ-010 SHALL have port overrun, output, 1, meaning a one-cycle pulse when a completed frame is dropped.

Function
REQ-011 SHALL pass seg_in and dig_en_n through a 2-flop synchroniser before any use.
REQ-012 SHALL treat a synchronised sample as valid only when exactly one dig_en_n bit is 0; an invalid sample clears the run counter.
REQ-013 SHALL clear the run counter whenever the synchronised {dig_en_n, seg_in} differs from the previous cycle, and increment it, saturating, otherwise.
REQ-014 SHALL capture once per stable run, on the cycle the run reaches STABLE_CYC identical valid samples, and SHALL NOT recapture until the run is broken.
REQ-015 SHALL make a capture visible at edge N+STABLE_CYC+2 when inputs become stable before edge N.
REQ-016 SHALL decode the patterns 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:27 D:21 E:06 F:0E (hex, 7-bit) to their nibble value.
REQ-017 SHALL ignore pattern 7F (blank): no capture and no error.
REQ-018 SHALL, on any other pattern at capture time, pulse dig_err for one cycle, capture nothing and leave the capture mask unchanged.
REQ-019 SHALL write the nibble into the capture register slot of the selected digit and set that bit in an 8-bit capture mask; recapturing a digit overwrites it.
REQ-020 SHALL run an FSM with two states. COLLECT: frame_valid=0. HOLD: frame_valid=1, frame_data stable.
REQ-021 SHALL, on the capture that sets the mask to FF, copy the capture register to frame_data, clear the mask, and go COLLECT→HOLD (frame_valid rises on that same edge).
REQ-022 SHALL return HOLD→COLLECT on a cycle with frame_valid && frame_ready.
REQ-023 SHALL continue collecting while in HOLD; if the mask completes while in HOLD without frame_ready that cycle, it SHALL pulse overrun, drop the new frame, clear the mask and keep the old frame_data.
REQ-024 SHALL, if the mask completes on the same cycle as frame_valid && frame_ready, load the new frame and remain in HOLD with no overrun.

Reset
REQ-025 SHALL on resetn=0 immediately clear the synchronisers (to all-ones), run counter, capture register, mask and frame_data; set the state to COLLECT; and drive frame_valid=0, dig_err=0 and overrun=0.
REQ-026 SHALL discard a partially collected frame when reset is asserted mid-frame and require all 8 digits afresh afterwards.

Configuration
REQ-027 SHALL, with macro SEGSCAN_ERR_CNT_EN defined, add output err_cnt[7:0] counting dig_err pulses, saturating at FF, and cleared by reset.
REQ-028 SHALL, without SEGSCAN_ERR_CNT_EN, omit the port and the counter entirely, with no other change in behaviour.

Verification
REQ-029 SHALL check this scan: digits 0..7 show patterns for 1,2,3,4,5,6,7,8, each held 10 cycles, frame_ready=1 → one frame_valid pulse with frame_data=0x87654321.
REQ-030 SHALL check this glitch: digit 3 held with pattern 24 for STABLE_CYC-1 cycles then changed → no capture of 2, and mask bit 3 stays clear.
REQ-031 SHALL check this error: digit 0 held at pattern 7E for 10 cycles → exactly one dig_err pulse, no capture; err_cnt=01 when the macro is defined.
REQ-032 SHALL check overrun: two full scans with frame_ready=0 → first frame held, overrun pulses once when the second completes, frame_data unchanged.
REQ-033 SHALL check invalid selects: dig_en_n=FC or FF with any seg_in for 20 cycles → no capture and no error.
REQ-034 SHALL check reset: resetn pulsed low after 5 of 8 digits captured → outputs cleared, and the next full scan yields exactly one frame.

Source files
------------

// File: rtl/segscan_rx.sv
// segscan_rx: recovers the digits of a multiplexed 7-segment display into a
// 32-bit frame word, with valid/ready hand-off and error/overrun pulses.
//
// Ports:
//   clock, resetn            clock, async active-low reset
//   seg_in[6:0]              active-low segments (bit6=g .. bit0=a), async
//   dig_en_n[7:0]            active-low one-hot digit select, async
//   frame_data[31:0]         assembled word, digit i in bits [4i+3:4i]
//   frame_valid/frame_ready  frame hand-off
//   dig_err                  1-cycle pulse on a stable unrecognised pattern
//   overrun                  1-cycle pulse when a completed frame is dropped
//   err_cnt[7:0]             dig_err count, saturating (SEGSCAN_ERR_CNT_EN only)
module segscan_rx #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  dig_en_n,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        dig_err,
    output logic        overrun
`ifdef SEGSCAN_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t      state;
    logic [14:0] sync1, sync2, prev;
    logic [3:0]  run_cnt;
    logic [31:0] cap_reg;
    logic [7:0]  mask;

    logic [7:0]  sel;
    logic        valid, same, fire;
    logic [2:0]  idx;
    logic [3:0]  nib;
    logic        known, blank;
    logic        cap_hit, err_hit, full;
    logic [31:0] cap_next;
    logic [7:0]  mask_next;

    assign sel   = ~sync2[14:7];
    assign valid = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    assign same  = (sync2 == prev);
    // One capture per run: the counter passes STABLE_CYC-1 only once
    // and saturates at 15, which is never below STABLE_CYC.
    assign fire  = valid && same && (run_cnt == 4'(STABLE_CYC - 1));
    assign blank = (sync2[6:0] == 7'h7F);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (sel[i]) idx = 3'(i);
    end

    always_comb begin
        nib   = 4'h0;
        known = 1'b1;
        case (sync2[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h27: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: known = 1'b0;
        endcase
    end

    assign cap_hit = fire && known;
    assign err_hit = fire && !known && !blank;

    always_comb begin
        cap_next = cap_reg;
        if (cap_hit) cap_next[{idx, 2'b00} +: 4] = nib;
    end

    assign mask_next = cap_hit ? (mask | sel) : mask;
    assign full      = cap_hit && (mask_next == 8'hFF);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1   <= '1;
            sync2   <= '1;
            prev    <= '1;
            run_cnt <= 4'd0;
        end else begin
            sync1 <= {dig_en_n, seg_in};
            sync2 <= sync1;
            prev  <= sync2;
            if (!valid || !same)
                run_cnt <= 4'd0;
            else if (run_cnt != 4'hF)
                run_cnt <= run_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= COLLECT;
            cap_reg     <= 32'd0;
            mask        <= 8'd0;
            frame_data  <= 32'd0;
            frame_valid <= 1'b0;
            dig_err     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            dig_err <= err_hit;
            overrun <= 1'b0;
            cap_reg <= cap_next;
            mask    <= full ? 8'd0 : mask_next;
            unique case (state)
                COLLECT: begin
                    if (full) begin
                        frame_data  <= cap_next;
                        frame_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (full) begin
                        // Accepted this cycle: swap in the new frame.
                        if (frame_ready) frame_data <= cap_next;
                        else             overrun    <= 1'b1;
                    end else if (frame_ready) begin
                        frame_valid <= 1'b0;
                        state       <= COLLECT;
                    end
                end
            endcase
        end
    end

`ifdef SEGSCAN_ERR_CNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            err_cnt <= 8'd0;
        else if (err_hit && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule
